control_unit: RTL
=================

# control_unit

Multi-cycle control FSM for the single-core matrix-multiplier processor. It fetches each instruction, decodes it, and drives the datapath strobes and the 3-bit `alu_op` into the ALU. It consumes the ALU's zero flag `z` for conditional jumps. It sits between the instruction/data memories, the register file/IR/PC datapath, and the ALU.

## Interface
- `MUL_CYCLES`, default 1: number of EXEC cycles for MUL, valid range 1–15.
- `DIV_CYCLES`, default 2: number of EXEC cycles for DIV, valid range 1–15.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle go pulse, honoured only in IDLE.
- `ir` in 8: instruction register contents; opcode `ir[7:4]`, operand register `ir[3:0]`.
- `z` in 1: ALU zero flag, 1 when `alu_out == 0`.
- `alu_op` out 3: 0 ADD, 1 SUB (in2−in1), 2 MUL, 3 DIV, 4 PASS in2.
- `bus_sel` out 4: register driving the ALU in1/address bus.
- `iram_re` out 1: instruction memory read strobe.
- `ir_load` out 1: latch instruction memory data into IR.
- `pc_inc` out 1: PC += 1.
- `pc_load` out 1: PC ← bus.
- `ac_load` out 1: AC ← `alu_out`.
- `dram_re` out 1: data memory read, address = bus.
- `dram_we` out 1: data memory write, address = bus, data = AC.
- `illegal` out 1: one-cycle pulse on an undefined or disabled opcode.
- `done` out 1: high while in HALT.

## Operation
- States: IDLE, FETCH1, FETCH2, DECODE, EXEC, MEM1, MEM2, HALT.
- IDLE → FETCH1 on `start`.
- FETCH1: `iram_re`=1. FETCH2: `ir_load`=1, `pc_inc`=1. DECODE: dispatch on `ir[7:4]`.
- Opcodes and their paths:
  - 0x0 NOP: DECODE → FETCH1.
  - 0x1 ADD, 0x2 SUB, 0x3 MUL, 0x4 DIV, 0x5 MOV: EXEC.
    - `alu_op` is 0/1/2/3/4 respectively.
    - `bus_sel`=`ir[3:0]` is held for the whole of EXEC.
    - EXEC lasts 1 cycle, or MUL_CYCLES / DIV_CYCLES.
    - `ac_load`=1 on the last EXEC cycle only.
  - 0x6 LDM: MEM1 (`dram_re`=1, `bus_sel`=`ir[3:0]`), then MEM2 (`alu_op`=4, `ac_load`=1).
  - 0x7 STM: EXEC, 1 cycle, `dram_we`=1, `bus_sel`=`ir[3:0]`.
  - 0x8 JMP: EXEC, 1 cycle, `pc_load`=1, `bus_sel`=`ir[3:0]`.
  - 0x9 JMPZ / 0xA JMPNZ: as JMP, but `pc_load` is asserted only if `zflag` is 1 / 0 respectively.
  - 0xF END: → HALT.
  - 0xB–0xE: `illegal` pulses in DECODE, then handled as NOP.
- After EXEC or MEM2, the FSM returns to FETCH1.
- `zflag` is an internal register.
  - It captures `z` on the `ac_load` cycle of ALU ops and LDM.
  - It is unchanged by all other instructions.
  - Reset value is 0.
- EXEC uses a 4-bit down-counter.
  - It is loaded in DECODE with cycles−1.
  - EXEC exits when the counter is 0.
- HALT is sticky: `done`=1 and `start` is ignored; only `rst` leaves HALT.
- `start` is ignored in every state except IDLE.

## Timing
- Reset:
  - `rst` overrides everything, including a simultaneous `start`.
  - The next state is IDLE, and `zflag` and the counter are cleared.
  - All outputs are 0 in the cycle after `rst` is sampled, including `alu_op`=0 and `done`=0.
  - The same applies to a reset mid-EXEC or mid-MEM: no strobe is asserted after the reset edge.
- All outputs are Moore outputs decoded from state and IR. They are glitch-free relative to `clk`, and no output depends combinationally on `start`.
- `iram_re` is asserted in FETCH1; instruction data is valid and latched in FETCH2, giving 1-cycle memory latency.
- `dram_re` is asserted in MEM1; data is valid in MEM2.
- Cycle counts per instruction:
  - NOP and illegal: 3 cycles.
  - ADD, SUB, MOV, STM, JMP, JMPZ, JMPNZ: 4 cycles.
  - MUL: 3+MUL_CYCLES. DIV: 3+DIV_CYCLES.
  - LDM: 5 cycles.
- `start` in IDLE at edge n puts the FSM in FETCH1 during cycle n+1.
- A conditional jump uses the `zflag` value as of the end of the previous instruction.
- An outside-range parameter value is clamped to 1.

## Configuration
- `CU_DIV_EN` defined:
  - Opcode 0x4 issues `alu_op`=3 for DIV_CYCLES cycles, then `ac_load`.
- `CU_DIV_EN` undefined:
  - Opcode 0x4 is illegal: `illegal` pulses in DECODE, and the instruction runs as a NOP.
  - `alu_op`=3 is never driven, and the DIV_CYCLES parameter is unused.

## Test plan
- `rst` high for 2 cycles → all outputs are 0 and the state is IDLE; `start` during `rst` → still IDLE afterwards.
- `start`, then `ir`=0x13 (ADD r3) → FETCH1/FETCH2/DECODE/EXEC sequence; `iram_re` in cycle 1, `ir_load`+`pc_inc` in cycle 2; EXEC shows `alu_op`=0, `bus_sel`=3, `ac_load`=1; FETCH1 in cycle 5.
- `ir`=0x32 (MUL r2) with MUL_CYCLES=3 → `alu_op`=2 held for 3 cycles, `ac_load` only on the third; `ir`=0x41 behaves per `CU_DIV_EN`: DIV with a 2-cycle EXEC, or `illegal` pulse plus NOP.
- SUB with `z`=1, then `ir`=0x95 (JMPZ r5) → `pc_load`=1, `bus_sel`=5; repeat with `z`=0 → `pc_load` stays 0; JMPNZ gives the inverse result.
- `ir`=0x64 (LDM r4) → MEM1 with `dram_re`=1 and `bus_sel`=4; MEM2 with `alu_op`=4 and `ac_load`=1; `ir`=0x72 (STM) → one `dram_we` cycle.
- `ir`=0xF0 (END) → `done`=1 held for ≥10 cycles despite `start` pulses; `rst` asserted mid-EXEC of a MUL → no `ac_load`, IDLE next cycle, `done`=0.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute control FSM driving datapath strobes and alu_op.
// Optional feature: define CU_DIV_EN to enable the DIV opcode (0x4); otherwise 0x4 is illegal.
module control_unit #(
   parameter int MUL_CYCLES = 1,
   parameter int DIV_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] ir,
   input  logic       z,
   output logic [2:0] alu_op,
   output logic [3:0] bus_sel,
   output logic       iram_re,
   output logic       ir_load,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       ac_load,
   output logic       dram_re,
   output logic       dram_we,
   output logic       illegal,
   output logic       done,
   output logic [2:0] state_dbg
);

   // Handshake: start is a level sampled on the rising edge and acted on only in IDLE;
   // every strobe is a Moore output of (state, ir), so none depends on start combinationally.

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH1 = 3'd1,
      S_FETCH2 = 3'd2,
      S_DECODE = 3'd3,
      S_EXEC   = 3'd4,
      S_MEM1   = 3'd5,
      S_MEM2   = 3'd6,
      S_HALT   = 3'd7
   } state_t;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_ADD   = 4'h1;
   localparam logic [3:0] OP_SUB   = 4'h2;
   localparam logic [3:0] OP_MUL   = 4'h3;
   localparam logic [3:0] OP_DIV   = 4'h4;
   localparam logic [3:0] OP_MOV   = 4'h5;
   localparam logic [3:0] OP_LDM   = 4'h6;
   localparam logic [3:0] OP_STM   = 4'h7;
   localparam logic [3:0] OP_JMP   = 4'h8;
   localparam logic [3:0] OP_JMPZ  = 4'h9;
   localparam logic [3:0] OP_JMPNZ = 4'hA;
   localparam logic [3:0] OP_END   = 4'hF;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_MUL  = 3'd2;
   localparam logic [2:0] ALU_DIV  = 3'd3;
   localparam logic [2:0] ALU_PASS = 3'd4;

   // Out-of-range cycle counts fall back to a single EXEC cycle.
   localparam logic [3:0] MUL_LAST = (MUL_CYCLES >= 1 && MUL_CYCLES <= 15) ?
                                     4'(MUL_CYCLES - 1) : 4'd0;
`ifdef CU_DIV_EN
   localparam logic [3:0] DIV_LAST = (DIV_CYCLES >= 1 && DIV_CYCLES <= 15) ?
                                     4'(DIV_CYCLES - 1) : 4'd0;
`endif

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       zflag;

   logic [3:0] opcode;
   logic [3:0] operand;
   logic       op_legal;
   logic       op_alu;
   logic [2:0] alu_code;
   logic [3:0] exec_last;

   assign opcode    = ir[7:4];
   assign operand   = ir[3:0];
   assign state_dbg = state;

   // Opcode classification, shared by DECODE dispatch and EXEC strobes.
   always_comb begin
      op_legal  = 1'b1;
      op_alu    = 1'b0;
      alu_code  = ALU_ADD;
      exec_last = 4'd0;
      case (opcode)
         OP_ADD: begin
            op_alu   = 1'b1;
            alu_code = ALU_ADD;
         end
         OP_SUB: begin
            op_alu   = 1'b1;
            alu_code = ALU_SUB;
         end
         OP_MUL: begin
            op_alu    = 1'b1;
            alu_code  = ALU_MUL;
            exec_last = MUL_LAST;
         end
`ifdef CU_DIV_EN
         OP_DIV: begin
            op_alu    = 1'b1;
            alu_code  = ALU_DIV;
            exec_last = DIV_LAST;
         end
`else
         OP_DIV: op_legal = 1'b0;
`endif
         OP_MOV: begin
            op_alu   = 1'b1;
            alu_code = ALU_PASS;
         end
         OP_NOP, OP_LDM, OP_STM, OP_JMP, OP_JMPZ, OP_JMPNZ, OP_END: op_legal = 1'b1;
         default: op_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
         zflag <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (ac_load)
            zflag <= z;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      alu_op    = ALU_ADD;
      bus_sel   = 4'd0;
      iram_re   = 1'b0;
      ir_load   = 1'b0;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      ac_load   = 1'b0;
      dram_re   = 1'b0;
      dram_we   = 1'b0;
      illegal   = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start)
               state_nxt = S_FETCH1;
         end
         S_FETCH1: begin
            iram_re   = 1'b1;
            state_nxt = S_FETCH2;
         end
         S_FETCH2: begin
            ir_load   = 1'b1;
            pc_inc    = 1'b1;
            state_nxt = S_DECODE;
         end
         S_DECODE: begin
            cnt_nxt = exec_last;
            if (!op_legal) begin
               illegal   = 1'b1;
               state_nxt = S_FETCH1;
            end else begin
               case (opcode)
                  OP_NOP:  state_nxt = S_FETCH1;
                  OP_LDM:  state_nxt = S_MEM1;
                  OP_END:  state_nxt = S_HALT;
                  default: state_nxt = S_EXEC;
               endcase
            end
         end
         S_EXEC: begin
            bus_sel = operand;
            if (op_alu) begin
               alu_op  = alu_code;
               ac_load = (cnt == 4'd0);
            end
            case (opcode)
               OP_STM:   dram_we = 1'b1;
               OP_JMP:   pc_load = 1'b1;
               OP_JMPZ:  pc_load = zflag;
               OP_JMPNZ: pc_load = ~zflag;
               default:  ;
            endcase
            if (cnt == 4'd0)
               state_nxt = S_FETCH1;
            else
               cnt_nxt = cnt - 4'd1;
         end
         S_MEM1: begin
            dram_re   = 1'b1;
            bus_sel   = operand;
            state_nxt = S_MEM2;
         end
         S_MEM2: begin
            alu_op    = ALU_PASS;
            ac_load   = 1'b1;
            state_nxt = S_FETCH1;
         end
         S_HALT: begin
            done = 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule
